// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the data RAM between the CPU (port 0) and the
// debug/program loader (port 1); all outputs, including the RAM strobes, are registered.
module ram_arbiter #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned WAIT = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_nRD,
    output logic          mem_nWR,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [3:0] CntInit = 4'(WAIT - 1);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic          busy_q, busy_d;
    logic          mem_nrd_q, mem_nrd_d, mem_nwr_q, mem_nwr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        win       = (req0 && req1) ? ~last_q : req1;
        sel_we    = win ? we1 : we0;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_nrd_d   = 1'b1;
        mem_nwr_d   = 1'b1;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    id_d        = win;
                    last_d      = win;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    cnt_d       = CntInit;
                    state_d     = StAccess;
                    gnt0_d      = ~win;
                    gnt1_d      = win;
                    mem_nrd_d   = sel_we;
                    mem_nwr_d   = ~sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d       = cnt_q - 4'd1;
                    mem_nrd_d   = we_q;
                    mem_nwr_d   = ~we_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                end else begin
                    // Last strobe cycle: RAM data is stable against the held address.
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    done0_d = ~id_q;
                    done1_d = id_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            rdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_nrd_q   <= 1'b1;
            mem_nwr_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            busy_q      <= busy_d;
            mem_nrd_q   <= mem_nrd_d;
            mem_nwr_q   <= mem_nwr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign mem_nRD   = mem_nrd_q;
    assign mem_nWR   = mem_nwr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    a_pulse_excl: assert property (@(posedge CLK) disable iff (!nRST)
        $onehot0({gnt0_q, gnt1_q, done0_q, done1_q}));
    a_strobe_excl: assert property (@(posedge CLK) disable iff (!nRST)
        mem_nrd_q || mem_nwr_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, checked cycle by
// cycle against a timestamp-based transaction model and a reference memory.
module tb_ram_arbiter;

    localparam int WAIT = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        withdraw;
    } txn_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  req_v = '0;
    logic [1:0]  we_v = '0;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic        gnt0, gnt1, done0, done1, busy, mem_nRD, mem_nWR;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 CLK = ~CLK;

    ram_arbiter #(.AW(32), .DW(32), .WAIT(WAIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .req0(req_v[0]), .we0(we_v[0]), .addr0(addr_v[0]), .wdata0(wdata_v[0]),
        .gnt0(gnt0), .done0(done0),
        .req1(req_v[1]), .we1(we_v[1]), .addr1(addr_v[1]), .wdata1(wdata_v[1]),
        .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .busy(busy), .mem_nRD(mem_nRD), .mem_nWR(mem_nWR),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Behavioural RAM: combinational read, write on clock while nWR is low.
    logic [31:0] ram [64];
    logic        ram_ready = 1'b0;
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge CLK) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (!mem_nWR) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: an access arbitrated in cycle T owns cycles T+1..T+WAIT+1.
    int          cyc = 0;
    logic        acc_valid = 1'b0;
    int          acc_t = 0;
    logic        acc_id = 1'b0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [31:0] acc_wdata = '0;
    logic        last_m = 1'b1;
    int          idle_from = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] ref_mem [64];
    logic [1:0]  pend = '0, granted = '0, done_seen = '0, withdraw_cur = '0;
    int          gnt_log[$];
    int          gnt_cyc[$];
    txn_t        txq0[$];
    txn_t        txq1[$];

    task automatic model_step();
        logic in_acc, is_gnt, is_done, bsy, w;
        if (!nRST) begin
            acc_valid = 1'b0;
            last_m    = 1'b1;
            idle_from = cyc;
            exp_rdata = '0;
            granted   = '0;
            done_seen = '0;
            check("rst_pulses", 32'({gnt0, gnt1, done0, done1, busy}), 32'd0);
            check("rst_strobes", 32'({mem_nRD, mem_nWR}), 32'd3);
            check("rst_rdata", rdata, 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
            check("rst_mem_wdata", mem_wdata, 32'd0);
        end else begin
            in_acc  = acc_valid && cyc >= acc_t + 1 && cyc <= acc_t + WAIT;
            is_gnt  = acc_valid && cyc == acc_t + 1;
            is_done = acc_valid && cyc == acc_t + WAIT + 1;
            bsy     = acc_valid && cyc >= acc_t + 1 && cyc <= acc_t + WAIT + 1;
            if (is_done) begin
                if (acc_we) ref_mem[acc_addr[7:2]] = acc_wdata;
                else exp_rdata = ref_mem[acc_addr[7:2]];
                granted[acc_id]   = 1'b0;
                done_seen[acc_id] = 1'b1;
            end
            check("gnt0", 32'(gnt0), 32'(is_gnt && !acc_id));
            check("gnt1", 32'(gnt1), 32'(is_gnt && acc_id));
            check("done0", 32'(done0), 32'(is_done && !acc_id));
            check("done1", 32'(done1), 32'(is_done && acc_id));
            check("busy", 32'(busy), 32'(bsy));
            check("mem_nRD", 32'(mem_nRD), 32'(!(in_acc && !acc_we)));
            check("mem_nWR", 32'(mem_nWR), 32'(!(in_acc && acc_we)));
            check("mem_addr", mem_addr, in_acc ? acc_addr : 32'd0);
            check("mem_wdata", mem_wdata, in_acc ? acc_wdata : 32'd0);
            check("rdata", rdata, exp_rdata);
            check("excl", 32'($countones({gnt0, gnt1, done0, done1}) <= 1), 32'd1);
            if (gnt0 || gnt1) begin
                gnt_log.push_back(gnt1 ? 1 : 0);
                gnt_cyc.push_back(cyc);
            end
            if (cyc >= idle_from && req_v != 2'b00) begin
                w         = (req_v == 2'b11) ? !last_m : req_v[1];
                acc_valid = 1'b1;
                acc_t     = cyc;
                acc_id    = w;
                acc_we    = we_v[w];
                acc_addr  = addr_v[w];
                acc_wdata = wdata_v[w];
                last_m    = w;
                idle_from = cyc + WAIT + 2;
                granted[w] = 1'b1;
            end
        end
        cyc++;
    endtask

    function automatic txn_t mk(logic we, logic [31:0] a, logic [31:0] d, logic wd);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.withdraw = wd;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        return mk(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FF3C, $urandom,
                  $urandom_range(0, 3) == 0);
    endfunction

    function automatic int qsize(int p);
        return (p == 0) ? txq0.size() : txq1.size();
    endfunction

    function automatic txn_t qpop(int p);
        if (p == 0) return txq0.pop_front();
        return txq1.pop_front();
    endfunction

    task automatic drive_txn(int p, txn_t t);
        req_v[p]        = 1'b1;
        we_v[p]         = t.we;
        addr_v[p]       = t.addr;
        wdata_v[p]      = t.wdata;
        withdraw_cur[p] = t.withdraw;
        pend[p]         = 1'b1;
    endtask

    // Requester behaviour: hold until done, optionally withdraw and scramble after grant.
    task automatic service(int p);
        if (done_seen[p]) begin
            done_seen[p] = 1'b0;
            pend[p]      = 1'b0;
            req_v[p]     = 1'b0;
            if (qsize(p) > 0) drive_txn(p, qpop(p));
        end else if (granted[p] && withdraw_cur[p] && req_v[p]) begin
            req_v[p]   = 1'b0;
            addr_v[p]  = 32'h40;
            wdata_v[p] = $urandom;
            we_v[p]    = ~we_v[p];
        end else if (!pend[p] && qsize(p) > 0) begin
            drive_txn(p, qpop(p));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        service(0);
        service(1);
        @(negedge CLK);
        model_step();
    endtask

    task automatic wait_idle(string tag, int budget);
        int n = 0;
        while ((pend != 2'b00 || txq0.size() > 0 || txq1.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, base;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;

        // Reset with both requests pending; CPU must win the first tie.
        txq0.push_back(mk(1'b0, 32'h10, 32'h0, 1'b0));
        txq1.push_back(mk(1'b1, 32'h8, 32'h1234_5678, 1'b0));
        txq0.push_back(mk(1'b0, 32'h8, 32'h0, 1'b0));
        service(0);
        service(1);
        repeat (3) tick();
        @(posedge CLK);
        #3 nRST = 1'b1;
        @(negedge CLK);
        model_step();
        check("first_grant_id", 32'(acc_id), 32'd0);
        wait_idle("drain_reset_rw", 40);
        check("readback_0x8", rdata, 32'h1234_5678);

        // Loader access first so the contention run starts with the CPU.
        txq1.push_back(mk(1'b1, 32'h24, 32'hCAFE_F00D, 1'b0));
        wait_idle("drain_loader", 20);
        base = gnt_log.size();
        for (int i = 0; i < 3; i++) begin
            txq0.push_back(mk(1'b0, 32'h100 + 32'(i * 4), 32'h0, 1'b0));
            txq1.push_back(mk(1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b0));
        end
        wait_idle("drain_contention", 60);
        check("contention_count", 32'(gnt_log.size() - base), 32'd6);
        for (int i = base; i < gnt_log.size(); i++) begin
            check("contention_order", 32'(gnt_log[i]), 32'((i - base) % 2));
            if (i > base) check("contention_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]),
                                32'(WAIT + 2));
        end

        // Withdrawal: req dropped and address moved after grant.
        txq0.push_back(mk(1'b0, 32'h20, 32'h0, 1'b1));
        wait_idle("drain_withdraw", 20);
        repeat (4) tick();

        // Reset during the second ACCESS cycle of a CPU read.
        txq0.push_back(mk(1'b0, 32'h30, 32'h0, 1'b0));
        n = 0;
        do begin
            tick();
            n++;
        end while (!granted[0] && n < 10);
        check("pre_reset_grant", 32'(granted[0]), 32'd1);
        tick();
        @(posedge CLK);
        #3 nRST = 1'b0;
        req_v[0] = 1'b0; pend[0] = 1'b0; withdraw_cur = '0;
        drive_txn(1, mk(1'b1, 32'h34, 32'h5A5A_0001, 1'b0));
        #1;
        check("midrst_strobes", 32'({mem_nRD, mem_nWR}), 32'd3);
        check("midrst_pulses", 32'({gnt0, gnt1, done0, done1, busy}), 32'd0);
        @(negedge CLK);
        model_step();
        repeat (2) tick();
        @(posedge CLK);
        #3 nRST = 1'b1;
        @(negedge CLK);
        model_step();
        tick();
        check("post_reset_gnt1", 32'(gnt1), 32'd1);
        wait_idle("drain_post_reset", 20);

        // Random traffic with occasional withdrawals and back-to-back requests.
        for (int i = 0; i < 1500; i++) begin
            if (txq0.size() < 2 && $urandom_range(0, 2) == 0) txq0.push_back(rnd_txn());
            if (txq1.size() < 2 && $urandom_range(0, 2) == 0) txq1.push_back(rnd_txn());
            tick();
        end
        wait_idle("drain_random", 200);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data RAM between two requesters.
- Requester 0 is the CPU load/store datapath (ALU-address / B-register write-data path). Requester 1 is the debug/program loader port.
- Arbitrates round-robin, registers the winning request, and drives the RAM's active-low nRD/nWR strobes for a fixed number of wait cycles.
- Returns read data with a one-cycle done pulse. Sits between the CPU core / loader and the RAM instance.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT, 1, number of cycles the RAM strobe is held per access; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- req0  input  1  CPU request; held high until done0.
- we0  input  1  CPU access type: 1 = write, 0 = read.
- addr0  input  AW  CPU byte address.
- wdata0  input  DW  CPU write data.
- gnt0  output  1  one-cycle pulse: CPU request accepted.
- done0  output  1  one-cycle pulse: CPU access complete.
- req1, we1, addr1, wdata1  input  1/1/AW/DW  loader request, same meaning as port 0.
- gnt1, done1  output  1/1  loader grant/done pulses.
- rdata  output  DW  read data; valid while doneX=1.
- busy  output  1  high in ACCESS and DONE.
- mem_nRD  output  1  RAM read strobe, active low.
- mem_nWR  output  1  RAM write strobe, active low.
- mem_addr  output  AW  RAM address.
- mem_wdata  output  DW  RAM write data.
- mem_rdata  input  DW  RAM combinational read data.

Behaviour:
- Reset values (asynchronous, while nRST=0):
  - state = IDLE; last = 1, so requester 0 wins the first tie.
  - gnt0/gnt1/done0/done1/busy = 0; mem_nRD = mem_nWR = 1; mem_addr = mem_wdata = 0; rdata = 0; wait counter = 0.
- FSM states IDLE, ACCESS, DONE. All outputs are registered.
- IDLE, arbitration:
  - Only req0 high → grant 0. Only req1 high → grant 1.
  - Both high → grant the requester != last.
  - On grant: latch winner id, we, addr, wdata; set last = winner; cnt = WAIT-1; next state ACCESS.
  - No request → stay in IDLE.
- ACCESS:
  - gntX = 1 in the first ACCESS cycle only.
  - mem_addr / mem_wdata driven from the latched values.
  - Read: mem_nRD = 0, mem_nWR = 1. Write: mem_nWR = 0, mem_nRD = 1.
  - Strobe held for exactly WAIT cycles. Each cycle: cnt != 0 → decrement; cnt == 0 → capture mem_rdata into rdata (reads only), go to DONE.
- DONE:
  - Strobes = 1; mem_addr / mem_wdata return to 0.
  - doneX = 1 for the latched winner. rdata is valid for reads; for writes it holds its previous value.
  - Next state IDLE unconditionally.
- Latency:
  - Request sampled in IDLE cycle T.
  - gnt and strobe in cycles T+1 .. T+WAIT.
  - done in cycle T+WAIT+1.
  - Earliest next arbitration in cycle T+WAIT+2.
  - Per-access cost is WAIT+2 cycles.
- Handshake rules:
  - The requester holds req, we, addr, wdata stable until done.
  - Changes after the grant are ignored, because the access uses the latched copy.
  - req dropped after the grant: the access still completes and done still pulses.
  - req still high in the IDLE cycle after done: treated as a new request.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1…; neither requester waits more than one access.
- At most one of gnt0/gnt1/done0/done1 is high in any cycle; gnt and done never coincide.
- Reset mid-access: strobes return high asynchronously, no done is issued, FSM restarts in IDLE; the interrupted write may or may not have landed.
- No address alignment checking or translation: addresses pass through unchanged.

Test Plan:
- Reset values: hold nRST=0 with req0=req1=1 → mem_nRD=mem_nWR=1, all gnt/done=0, rdata=0. Release → first grant goes to 0.
- Single read, WAIT=2: req0=1, we0=0, addr0=0x10, RAM returns 0xDEADBEEF → gnt0 at T+1; mem_nRD=0 with mem_addr=0x10 for exactly 2 cycles; done0 at T+3 with rdata=0xDEADBEEF.
- Loader write, WAIT=1: req1=1, we1=1, addr1=0x8, wdata1=0x12345678 → mem_nWR=0 for one cycle with correct addr/data, mem_nRD stays 1; done1 next cycle; subsequent CPU read of 0x8 returns 0x12345678.
- Contention: req0 and req1 held high for 6 accesses → grant order 0,1,0,1,0,1; no two gnt/done pulses overlap; accesses spaced WAIT+2 cycles apart.
- Request withdrawal: drop req0 and change addr0 to 0x40 one cycle after gnt0 → access completes at the original address; done0 still pulses; no second access is issued.
- Reset mid-access, WAIT=4: assert nRST low during the 2nd ACCESS cycle → strobes high immediately, no done pulse; after release a pending req1 is granted within 1 cycle.
